// File: rtl/mixer_pkg.sv
// Shared types and constants for the sample mixer: sample width, FSM states, dither LFSR.
package mixer_pkg;

  localparam int unsigned SAMPLE_W = 8;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DIV,
    DONE
  } state_e;

  function automatic logic [SAMPLE_W-1:0] saturate(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[SAMPLE_W-1:0];
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sample_mixer_if.sv
// Mixer request/result bundle; master drives ticks and voices, slave is the mixer.
interface sample_mixer_if #(
  parameter int unsigned NUM_VOICES = 4
);
  import mixer_pkg::*;

  logic                           sample_tick;
  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples;
  logic [NUM_VOICES-1:0]          voice_active;
  logic [SAMPLE_W-1:0]            mixed_sample;
  logic                           sample_valid;
  logic                           busy;
  logic                           overrun;

  modport master (
    output sample_tick, voice_samples, voice_active,
    input  mixed_sample, sample_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, voice_samples, voice_active,
    output mixed_sample, sample_valid, busy, overrun
  );

endinterface

// File: rtl/serial_divider.sv
// Restoring serial divider: one quotient bit per cycle for SUM_W cycles after start.
// A zero divisor yields a zero quotient with unchanged latency.
module serial_divider #(
  parameter int unsigned SUM_W = 10,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int unsigned STEP_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;
  logic [CNT_W:0]    trial_c;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    steps_d = steps_q;
    zero_d  = zero_q;
    trial_c = {rem_q, quo_q[SUM_W-1]};
    if (start) begin
      quo_d   = dividend;
      rem_d   = '0;
      div_d   = divisor;
      zero_d  = (divisor == '0);
      steps_d = STEP_W'(SUM_W);
    end else if (steps_q != '0) begin
      steps_d = steps_q - STEP_W'(1);
      if (trial_c >= {1'b0, div_q}) begin
        rem_d = CNT_W'(trial_c - {1'b0, div_q});
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial_c[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end
    end
    // done marks the cycle whose closing edge performs the final step
    done_d = (steps_d == STEP_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      steps_q <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      steps_q <= steps_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign quotient = zero_q ? '0 : quo_q;
  assign done     = done_q;

endmodule

// File: rtl/sample_mixer.sv
// Averages the active voices on each sample tick and holds the result for the PWM stage.
// Optional MIXER_DITHER_EN adds an LFSR bit to the quotient before saturation.
module sample_mixer
  import mixer_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic clk,
  input  logic rst,
  sample_mixer_if.slave bus
);

  localparam int unsigned SUM_W = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int unsigned CNT_W = $clog2(NUM_VOICES + 1);
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  state_e                         state_q;
  logic [NUM_VOICES*SAMPLE_W-1:0] snap_q;
  logic [NUM_VOICES-1:0]          mask_q;
  logic [IDX_W-1:0]               idx_q;
  logic [SUM_W-1:0]               sum_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [SAMPLE_W-1:0]            mixed_q;
  logic                           valid_q;
  logic                           busy_q;
  logic                           overrun_q;
`ifdef MIXER_DITHER_EN
  logic [7:0]                     lfsr_q;
`endif

  logic [SAMPLE_W-1:0] voice_c;
  logic                active_c;
  logic                last_c;
  logic [SUM_W-1:0]    sum_next_c;
  logic [CNT_W-1:0]    cnt_next_c;
  logic [SUM_W:0]      result_c;
  logic                div_start_c;
  logic [SUM_W-1:0]    quotient;
  logic                div_done;

  // Select the snapshot voice addressed by the accumulation index
  always_comb begin
    voice_c  = '0;
    active_c = 1'b0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (IDX_W'(i) == idx_q) begin
        voice_c  = snap_q[i*SAMPLE_W +: SAMPLE_W];
        active_c = mask_q[i];
      end
    end
  end

  assign last_c      = (idx_q == IDX_W'(NUM_VOICES - 1));
  assign sum_next_c  = sum_q + (active_c ? SUM_W'(voice_c) : SUM_W'(0));
  assign cnt_next_c  = cnt_q + (active_c ? CNT_W'(1) : CNT_W'(0));
  assign div_start_c = (state_q == ACCUM) && last_c;

`ifdef MIXER_DITHER_EN
  assign result_c = {1'b0, quotient} + (SUM_W + 1)'(lfsr_q[0]);
`else
  assign result_c = {1'b0, quotient};
`endif

  serial_divider #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (sum_next_c),
    .divisor  (cnt_next_c),
    .quotient (quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      mixed_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef MIXER_DITHER_EN
      lfsr_q    <= LFSR_SEED;
`endif
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.sample_tick) begin
            snap_q  <= bus.voice_samples;
            mask_q  <= bus.voice_active;
            sum_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
`ifdef MIXER_DITHER_EN
            lfsr_q  <= lfsr_next(lfsr_q);
`endif
          end
        end
        ACCUM: begin
          sum_q <= sum_next_c;
          cnt_q <= cnt_next_c;
          idx_q <= idx_q + IDX_W'(1);
          if (last_c) state_q <= DIV;
        end
        DIV: begin
          if (div_done) state_q <= DONE;
        end
        DONE: begin
          mixed_q <= saturate(16'(result_c));
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A tick in any non-idle state, including DONE, is dropped
      if (bus.sample_tick && (state_q != IDLE)) overrun_q <= 1'b1;
    end
  end

  assign bus.mixed_sample = mixed_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;

endmodule
